// File: rtl/thor2024_lda_agen.sv
// Thor2024 LDA/LDAX address generator: two-stage valid/ready pipeline computing
// base + disp + (index << scale) as a register result, with flush and async reset.
module thor2024_lda_agen #(
   parameter int WID  = 64,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_valid,
   output logic            i_ready,
   input  logic            i_ldax,
   input  logic [WID-1:0]  i_a,
   input  logic [WID-1:0]  i_b,
   input  logic [1:0]      i_scale,
   input  logic [WID-1:0]  i_disp,
   input  logic [TAGW-1:0] i_tag,
   input  logic            flush,
   output logic            o_valid,
   input  logic            o_ready,
   output logic [WID-1:0]  o_res,
   output logic [TAGW-1:0] o_tag
);

   // Handshake: a transfer happens on an edge where valid & ready are both high.
   // ready never depends on valid; flush blocks acceptance for its cycle.
   logic            s1_v;
   logic [WID-1:0]  s1_sx;
   logic [WID-1:0]  s1_bd;
   logic [TAGW-1:0] s1_tag;
   logic            s2_v;
   logic [WID-1:0]  s2_res;
   logic [TAGW-1:0] s2_tag;

   logic adv1;
   logic adv2;
   logic accept;

   assign adv2    = !s2_v | o_ready;
   assign adv1    = !s1_v | adv2;
   assign i_ready = adv1 & !flush;
   assign accept  = i_valid & i_ready;

   assign o_valid = s2_v;
   assign o_res   = s2_res;
   assign o_tag   = s2_tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s1_sx  <= '0;
         s1_bd  <= '0;
         s1_tag <= '0;
         s2_v   <= 1'b0;
         s2_res <= '0;
         s2_tag <= '0;
      end else begin
         if (flush)
            s1_v <= 1'b0;
         else if (adv1)
            s1_v <= accept;

         // All sums/shifts wrap modulo 2^WID by truncation to the register width.
         if (accept) begin
            s1_sx  <= i_ldax ? (i_b << i_scale) : '0;
            s1_bd  <= i_a + i_disp;
            s1_tag <= i_tag;
         end

         if (flush)
            s2_v <= 1'b0;
         else if (adv2)
            s2_v <= s1_v;

         // Data only moves when a real op advances, so an idle pipe holds its outputs.
         if (adv2 && s1_v && !flush) begin
            s2_res <= s1_bd + s1_sx;
            s2_tag <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_thor2024_lda_agen.sv
// Scoreboard bench for thor2024_lda_agen: issue-side driver pushes model results,
// an independent monitor pops and compares on every output transfer.
module tb_thor2024_lda_agen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic        i_ldax = 1'b0;
   logic [63:0] i_a = '0;
   logic [63:0] i_b = '0;
   logic [1:0]  i_scale = '0;
   logic [63:0] i_disp = '0;
   logic [4:0]  i_tag = '0;
   logic        flush = 1'b0;
   logic        o_valid;
   logic        o_ready = 1'b0;
   logic [63:0] o_res;
   logic [4:0]  o_tag;

   int n_cmp = 0;
   int n_err = 0;
   int n_xfer = 0;
   logic [68:0] exp_q[$];

   always #5 clk = ~clk;

   thor2024_lda_agen #(.WID(64), .TAGW(5)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
      .i_ldax(i_ldax), .i_a(i_a), .i_b(i_b), .i_scale(i_scale),
      .i_disp(i_disp), .i_tag(i_tag), .flush(flush),
      .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res), .o_tag(o_tag)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Effective address from the ISA definition: base + disp + index * 2^scale, mod 2^64.
   function automatic logic [63:0] model(input logic ld, input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] sc, input logic [63:0] d);
      logic [63:0] mult;
      mult = 64'd1 << sc;
      return a + d + (ld ? b * mult : 64'd0);
   endfunction

   task automatic cycle(input logic v, input logic ld, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] sc, input logic [63:0] d, input logic [4:0] t,
                        input logic ordy, input logic fl, output logic acc);
      @(negedge clk);
      i_valid = v; i_ldax = ld; i_a = a; i_b = b; i_scale = sc; i_disp = d; i_tag = t;
      o_ready = ordy; flush = fl;
      #1;
      acc = i_valid && i_ready;
      if (acc) exp_q.push_back({t, model(ld, a, b, sc, d)});
      #2;
      if (fl) exp_q.delete();
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      cycle(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 64'd0, 5'd0, ordy, 1'b0, acc);
   endtask

   task automatic directed(input string name, input logic ld, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] sc, input logic [63:0] d, input logic [4:0] t,
                           input logic [63:0] exp_res);
      logic acc;
      cycle(1'b1, ld, a, b, sc, d, t, 1'b1, 1'b0, acc);
      check({name, "_accept"}, {63'd0, acc}, 64'd1);
      idle(1'b1);
      check({name, "_not_yet"}, {63'd0, o_valid}, 64'd0);
      idle(1'b1);
      check({name, "_valid"}, {63'd0, o_valid}, 64'd1);
      check({name, "_res"}, o_res, exp_res);
      check({name, "_tag"}, {59'd0, o_tag}, {59'd0, t});
      idle(1'b1);
   endtask

   // Monitor: scoreboard pop on transfer, plus output stability across stalls.
   logic        stall_prev = 1'b0;
   logic [63:0] res_prev;
   logic [4:0]  tag_prev;
   logic [68:0] exp_item;
   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", {63'd0, o_valid}, 64'd1);
            check("stall_res", o_res, res_prev);
            check("stall_tag", {59'd0, o_tag}, {59'd0, tag_prev});
         end
         if (o_valid && o_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL spurious_result: got tag %0d res %h, expected none", o_tag, o_res);
            end else begin
               exp_item = exp_q.pop_front();
               check("sb_res", o_res, exp_item[63:0]);
               check("sb_tag", {59'd0, o_tag}, {59'd0, exp_item[68:64]});
            end
         end
         stall_prev = o_valid && !o_ready && !flush;
         res_prev = o_res;
         tag_prev = o_tag;
      end
   end

   initial begin
      #200000;
      n_cmp++;
      n_err++;
      $display("FAIL timeout: simulation still running, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      logic acc;
      int   acc_cnt;
      int   x0;
      int   guard;

      #2;
      check("rst_o_valid", {63'd0, o_valid}, 64'd0);
      check("rst_o_res", o_res, 64'd0);
      check("rst_o_tag", {59'd0, o_tag}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_i_ready", {63'd0, i_ready}, 64'd1);

      directed("lda", 1'b0, 64'h1000, 64'h0, 2'd0, 64'hFFFF_FFFF_FFFF_FFF0, 5'd3, 64'h0FF0);
      directed("ldax", 1'b1, 64'h2000, 64'h10, 2'd3, 64'd8, 5'd4, 64'h2088);
      directed("lda_same", 1'b0, 64'h2000, 64'h10, 2'd3, 64'd8, 5'd5, 64'h2008);
      directed("wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 64'd1, 5'd6, 64'd1);

      // Back-to-back: 8 ops, results must stream out on 8 consecutive cycles.
      acc_cnt = 0;
      x0 = n_xfer;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
               2'($urandom_range(0, 3)), {$urandom, $urandom}, 5'(i), 1'b1, 1'b0, acc);
         if (acc) acc_cnt++;
      end
      for (int i = 0; i < 3; i++) idle(1'b1);
      check("b2b_accepts", 64'(acc_cnt), 64'd8);
      check("b2b_results", 64'(n_xfer - x0), 64'd8);

      // Backpressure: only two ops fit while writeback is blocked.
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, {$urandom, $urandom}, 64'(i), 2'd1, 64'd0, 5'(10 + i), 1'b0, 1'b0, acc);
         if (acc) acc_cnt++;
      end
      check("bp_accepts", 64'(acc_cnt), 64'd2);
      check("bp_i_ready", {63'd0, i_ready}, 64'd0);
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Flush with both stages full: nothing survives.
      for (int i = 0; i < 2; i++)
         cycle(1'b1, 1'b0, 64'(100 + i), 64'd0, 2'd0, 64'd0, 5'(20 + i), 1'b0, 1'b0, acc);
      cycle(1'b1, 1'b0, 64'd200, 64'd0, 2'd0, 64'd0, 5'd22, 1'b0, 1'b1, acc);
      check("flush_no_accept", {63'd0, acc}, 64'd0);
      idle(1'b0);
      check("flush_o_valid", {63'd0, o_valid}, 64'd0);
      check("flush_i_ready", {63'd0, i_ready}, 64'd1);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Flush while a result transfers: that result still counts.
      for (int i = 0; i < 2; i++)
         cycle(1'b1, 1'b0, 64'(300 + i), 64'd0, 2'd0, 64'd0, 5'(24 + i), 1'b0, 1'b0, acc);
      x0 = n_xfer;
      cycle(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 64'd0, 5'd0, 1'b1, 1'b1, acc);
      check("flush_xfer", 64'(n_xfer - x0), 64'd1);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Randomized traffic with random backpressure and occasional flushes.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), {$urandom, $urandom},
               {$urandom, $urandom}, 2'($urandom_range(0, 3)), {$urandom, $urandom},
               5'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0), acc);
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         idle(1'b1);
         guard++;
      end
      check("rand_drained", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 2; i++)
         cycle(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 2'd2, 64'd5, 5'(i), 1'b0, 1'b0, acc);
      @(negedge clk);
      i_valid = 1'b0;
      #4;
      rst = 1'b1;
      #1;
      check("arst_o_valid", {63'd0, o_valid}, 64'd0);
      check("arst_o_res", o_res, 64'd0);
      exp_q.delete();
      @(negedge clk);
      #4;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) idle(1'b1);
      check("arst_quiet", {63'd0, o_valid}, 64'd0);
      directed("after_rst", 1'b1, 64'h40, 64'h3, 2'd2, 64'h4, 5'd9, 64'h50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
